jk_cmd_driver: RTL

- Upstream driver stage for the team's JK flip-flop: accepts queued bit-level commands (hold, clear, set, toggle, each with a repeat length) and drives the flip-flop's j/k inputs one command-cycle per clock.
- Keeps a reference model of the expected flip-flop output and compares it against the fed-back q, raising a sticky mismatch flag.
- Sits between a command source (bench or controller) and the flip-flop, with q wired back to q_fb.

---
 rtl/jk_cmd_driver_if.sv | 10 +
 rtl/jk_cmd_driver.sv | 99 +++++++++
 2 files changed

// File: rtl/jk_cmd_driver_if.sv
// Command handshake between a command source and jk_cmd_driver.
interface jk_cmd_driver_if #(parameter int CNT_W = 8);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_len;

    modport master (output cmd_valid, cmd_op, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_driver.sv
// Queued JK command driver with an expected-q model and a sticky q_fb checker.
// States: IDLE | no command driven, j=k=0 ;  RUN | command driven for rem+1 more cycles
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    jk_cmd_driver_if.slave  i_cmd,
    input  logic            i_q_fb,
    output logic            o_ff_rst,
    output logic            o_j,
    output logic            o_k,
    output logic            o_exp_q,
    output logic            o_busy,
    output logic            o_mismatch
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [CNT_W+1:0] r_fifo [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [CNT_W-1:0] r_rem;
    logic             r_j;
    logic             r_k;
    logic             r_exp_q;
    logic             r_mismatch;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_head_op;
    logic [CNT_W-1:0] w_head_len;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign i_cmd.cmd_ready = i_rst && !w_full;
    assign w_push  = i_cmd.cmd_valid && i_cmd.cmd_ready;
    // next command is taken on the same edge the current one runs out, so no idle bubble
    assign w_pop   = !w_empty && ((r_state == IDLE) || (r_rem == '0));
    assign {w_head_op, w_head_len} = r_fifo[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo[r_wptr[AW-1:0]] <= {i_cmd.cmd_op, i_cmd.cmd_len};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_rem      <= '0;
            r_j        <= 1'b0;
            r_k        <= 1'b0;
            r_exp_q    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);

            case ({r_j, r_k})
                2'b01:   r_exp_q <= 1'b0;
                2'b10:   r_exp_q <= 1'b1;
                2'b11:   r_exp_q <= ~r_exp_q;
                default: r_exp_q <= r_exp_q;
            endcase
            r_mismatch <= r_mismatch | (i_q_fb ^ r_exp_q);

            // op encoding maps directly onto {j, k}
            if (w_pop) begin
                r_state <= RUN;
                r_rem   <= w_head_len;
                r_j     <= w_head_op[1];
                r_k     <= w_head_op[0];
            end else if (r_state == RUN) begin
                if (r_rem != '0) begin
                    r_rem <= r_rem - CNT_W'(1);
                end else begin
                    r_state <= IDLE;
                    r_j     <= 1'b0;
                    r_k     <= 1'b0;
                end
            end
        end
    end

    assign o_ff_rst   = ~i_rst;
    assign o_j        = r_j;
    assign o_k        = r_k;
    assign o_exp_q    = r_exp_q;
    assign o_mismatch = r_mismatch;
    assign o_busy     = (r_state == RUN) || !w_empty;
endmodule
